// File: rtl/cla_pipe_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encoding and pipeline geometry helpers.
package cla_pipe_addsub_pkg;

   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;
   localparam int   BLK_BITS = 4;

   function automatic int num_stages(input int width, input int blk_per_stage);
      return width / (BLK_BITS * blk_per_stage);
   endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational lookahead slice: BLK 4-bit P/G blocks chained by block
// generate/propagate, with slice-level PP/GG and a zero detect.
module cla_slice
   import cla_pipe_addsub_pkg::*;
#(
   parameter int BLK = 2
) (
   input  logic [BLK_BITS*BLK-1:0] a,
   input  logic [BLK_BITS*BLK-1:0] b,
   input  logic                    cin,
   output logic [BLK_BITS*BLK-1:0] s,
   output logic                    cout,
   output logic                    pp,
   output logic                    gg,
   output logic                    zero
);

   logic [BLK_BITS*BLK-1:0] c;
   logic [BLK-1:0]          bp;
   logic [BLK-1:0]          bg;
   logic [BLK:0]            bc;

   for (genvar j = 0; j < BLK; j++) begin : g_blk
      localparam int B = j * BLK_BITS;
      logic [3:0] p;
      logic [3:0] g;

      assign p     = a[B +: 4] ^ b[B +: 4];
      assign g     = a[B +: 4] & b[B +: 4];
      assign bp[j] = &p;
      assign bg[j] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

      // Bit carries are flattened from the block carry-in, no ripple inside the block.
      assign c[B]     = bc[j];
      assign c[B + 1] = g[0] | (p[0] & bc[j]);
      assign c[B + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bc[j]);
      assign c[B + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bc[j]);
      assign s[B +: 4] = p ^ c[B +: 4];
   end

   // NOTE: every combinational output gets a value before the loop so no latch is inferred.
   always_comb begin
      bc[0] = cin;
      pp    = bp[0];
      gg    = bg[0];
      for (int j = 0; j < BLK; j++) begin
         bc[j + 1] = bg[j] | (bp[j] & bc[j]);
      end
      for (int j = 1; j < BLK; j++) begin
         gg = bg[j] | (bp[j] & gg);
         pp = pp & bp[j];
      end
   end

   assign cout = bc[BLK];
   assign zero = ~|s;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined adder/subtractor: one lookahead slice per stage, carry and partial
// results registered between stages, single global advance enable.
module cla_pipe_addsub
   import cla_pipe_addsub_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int BLK_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int SW     = BLK_BITS * BLK_PER_STAGE;
   localparam int STAGES = num_stages(WIDTH, BLK_PER_STAGE);
   localparam int LAST   = STAGES - 1;

   logic              en;
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [WIDTH-1:0]  s_n [STAGES];
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [SW-1:0]     sl_s [STAGES];
   logic [STAGES-1:0] c_d, z_d, v_d, z_n;
   logic [STAGES-1:0] c_q, z_q, v_q;
   logic [STAGES-1:0] sl_c, sl_z, sl_pp, sl_gg;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // Stage 0 sees the raw inputs with b pre-inverted for SUB; later stages see the previous register.
   always_comb begin
      a_d[0] = a;
      b_d[0] = (op == OP_ADD) ? b : ~b;
      c_d[0] = (op == OP_SUB) ? 1'b1 : c_in;
      s_d[0] = '0;
      z_d[0] = 1'b1;
      v_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         c_d[k] = c_q[k-1];
         s_d[k] = s_q[k-1];
         z_d[k] = z_q[k-1];
         v_d[k] = v_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_slice #(.BLK(BLK_PER_STAGE)) u_slice (
         .a    (a_d[k][k*SW +: SW]),
         .b    (b_d[k][k*SW +: SW]),
         .cin  (c_d[k]),
         .s    (sl_s[k]),
         .cout (sl_c[k]),
         .pp   (sl_pp[k]),
         .gg   (sl_gg[k]),
         .zero (sl_z[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         s_n[k]              = s_d[k];
         s_n[k][k*SW +: SW]  = sl_s[k];
         z_n[k]              = z_d[k] & sl_z[k];
      end
   end

   // NOTE: data registers are reset along with the valid bits so sum and flags read 0 out of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q <= '0;
         z_q <= '0;
         v_q <= '0;
      end else if (en) begin
         // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_n[k];
         end
         c_q <= sl_c;
         z_q <= z_n;
         v_q <= v_d;
      end
   end

   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign c_out     = c_q[LAST];
   assign zero      = z_q[LAST];
   assign neg       = s_q[LAST][WIDTH-1];
   assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                      (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

   // Only the operand sign bits matter at the last stage; slice PP/GG are spare lookahead terms.
   logic unused_bits;
   assign unused_bits = ^{a_q[LAST][WIDTH-2:0], b_q[LAST][WIDTH-2:0], sl_pp, sl_gg};

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: directed vector table, stall and
// reset sequences, and a random scoreboard run against a behavioural model.
module tb_cla_pipe_addsub;
   import cla_pipe_addsub_pkg::*;

   localparam int STAGES = 4;
   localparam int NV     = 11;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        c;
      logic        v;
      logic        z;
      logic        n;
   } vec_t;

   typedef struct {
      logic [35:0] exp;
      int          cyc;
      string       name;
   } exp_t;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        in_valid = 1'b0;
   logic        op       = 1'b0;
   logic        c_in     = 1'b0;
   logic [31:0] a        = '0;
   logic [31:0] b        = '0;
   logic        out_ready;
   logic        in_ready, out_valid, c_out, ovf, zero, neg;
   logic [31:0] sum;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          rdy_mode = 1;
   logic        lat_chk  = 1'b0;
   logic        use_tab  = 1'b0;
   logic [35:0] tab_exp  = '0;
   string       cur_name = "";
   exp_t        sb[$];
   exp_t        ent;
   vec_t        tab [NV];

   cla_pipe_addsub #(.WIDTH(32), .BLK_PER_STAGE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Result packed as {sum, c_out, ovf, zero, neg}.
   function automatic logic [35:0] model(input logic sub, input logic [31:0] x, input logic [31:0] y,
                                         input logic ci);
      logic [32:0] r;
      logic        v;
      if (sub) begin
         r[31:0] = x - y;
         r[32]   = (x >= y);
         v       = (x[31] != y[31]) && (r[31] != x[31]);
      end else begin
         r = {1'b0, x} + {1'b0, y} + {32'd0, ci};
         v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      return {r[31:0], r[32], v, r[31:0] == 32'd0, r[31]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'($urandom_range(0, 3));
         default: return $urandom();
      endcase
   endfunction

   // Downstream ready: 0 = hold low, 1 = hold high, otherwise random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Scoreboard: transfers are decided at the next rising edge, so sample on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            check("result_expected", 36'(sb.size() != 0), 36'd1);
            if (sb.size() != 0) begin
               ent = sb.pop_front();
               check(ent.name, {sum, c_out, ovf, zero, neg}, ent.exp);
               if (lat_chk) check({ent.name, "_latency"}, 36'(cyc - ent.cyc), 36'(STAGES));
            end
         end
         if (in_valid && in_ready) begin
            ent.exp  = use_tab ? tab_exp : model(op, a, b, c_in);
            ent.cyc  = cyc;
            ent.name = cur_name;
            sb.push_back(ent);
         end
      end
   end

   task automatic present(input logic o, input logic [31:0] x, input logic [31:0] y, input logic ci,
                          input logic ut, input logic [35:0] e, input string nm);
      op       = o;
      a        = x;
      b        = y;
      c_in     = ci;
      use_tab  = ut;
      tab_exp  = e;
      cur_name = nm;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept();
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 1000 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      check("in_accepted", 36'(acc), 36'd1);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic o, input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic ut, input logic [35:0] e, input string nm);
      present(o, x, y, ci, ut, e, nm);
      wait_accept();
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
      check("drain_empty", 36'(sb.size()), 36'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tab[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tab[1]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      tab[2]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[3]  = '{OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 1'b0};
      tab[4]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tab[5]  = '{OP_SUB, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tab[6]  = '{OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
      tab[7]  = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[8]  = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
      tab[9]  = '{OP_SUB, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b0};
      tab[10] = '{OP_ADD, 32'h00FF_00FF, 32'h0F0F_0F0F, 1'b0, 32'h100E_100E, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 36'(out_valid), 36'd0);
      check("rst_outputs", {sum, c_out, ovf, zero, neg}, 36'd0);
      check("rst_in_ready", 36'(in_ready), 36'd1);
      @(posedge clk);
      #1;

      // Directed table, issued back to back with exact latency checked
      rdy_mode = 1;
      lat_chk  = 1'b1;
      for (int i = 0; i < NV; i++) begin
         send(tab[i].op, tab[i].a, tab[i].b, tab[i].cin, 1'b1,
              {tab[i].sum, tab[i].c, tab[i].v, tab[i].z, tab[i].n}, $sformatf("vec%0d", i));
      end
      drain();
      lat_chk = 1'b0;

      // Fill the pipeline with downstream stalled, hold a fifth op at the input for 3 cycles
      rdy_mode = 0;
      for (int i = 0; i < 4; i++) begin
         send(i[0] ? OP_SUB : OP_ADD, $urandom(), $urandom(), 1'b0, 1'b0, '0, $sformatf("stall_op%0d", i));
      end
      present(OP_ADD, 32'h1234_0000, 32'h0000_5678, 1'b1, 1'b0, '0, "stall_op4");
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check($sformatf("stall_out_valid%0d", j), 36'(out_valid), 36'd1);
         check($sformatf("stall_in_ready%0d", j), 36'(in_ready), 36'd0);
         check($sformatf("stall_hold%0d", j), {sum, c_out, ovf, zero, neg}, sb[0].exp);
      end
      @(posedge clk);
      #1;
      rdy_mode = 1;
      wait_accept();
      drain();

      // Reset with three ops in flight: none of them may emerge
      for (int i = 0; i < 3; i++) begin
         send(OP_ADD, $urandom(), $urandom(), 1'b1, 1'b0, '0, $sformatf("rst_drop%0d", i));
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      check("rst2_out_valid", 36'(out_valid), 36'd0);
      check("rst2_outputs", {sum, c_out, ovf, zero, neg}, 36'd0);
      check("rst2_in_ready", 36'(in_ready), 36'd1);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;

      // Random traffic in both modes with random backpressure
      rdy_mode = 2;
      for (int i = 0; i < 10000; i++) begin
         send(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0, '0, "rand");
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
